systolic_feeder: RTL and testbench
==================================

Name: systolic_feeder

Overview:
- Transmit side of the systolic array's buffer-push interface; one instance drives the "up" port set, another drives the "left" port set.
- Collects a row stream (one ARRAY_DIM-wide operand vector per beat) into chunks of up to BUFFER_SZ rows.
- Hands each chunk to the array with a 4-phase wen/pushed handshake, together with the chunk row count and the job's total row count.
- Sits between the operand DMA/stream unpacker and the systolic array.

Parameters:
- BIT_WIDTH, 8, operand element width
- BUFFER_SZ, 32, max rows per chunk
- INDEX_WIDTH, 6, width of chunk row count; must hold BUFFER_SZ
- ARRAY_DIM, 32, elements per row
- STREAM_WIDTH, 32, width of total row count

Ports:
- clk  in  1  clock; all logic on rising edge
- resetn  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle job start pulse
- cfg_total  in  STREAM_WIDTH  rows in job; sampled on accepted start
- s_data  in  ARRAY_DIM*BIT_WIDTH  row; element e at bits [BIT_WIDTH*e +: BIT_WIDTH]
- s_valid  in  1  row valid
- s_ready  out  1  row accepted when s_valid & s_ready
- out_buffer  out  BUFFER_SZ*ARRAY_DIM*BIT_WIDTH  chunk; row k at [k*ARRAY_DIM*BIT_WIDTH +: ARRAY_DIM*BIT_WIDTH]
- out_index  out  INDEX_WIDTH  rows valid in out_buffer
- out_total  out  STREAM_WIDTH  latched cfg_total
- wen  out  1  chunk-available request
- pushed  in  1  array acknowledge
- busy  out  1  job in progress
- done  out  1  one-cycle pulse after the last chunk is released

Behaviour:
- Reset state: s_ready=0, wen=0, busy=0, done=0, out_buffer=0, out_index=0, out_total=1, state IDLE.
  - Reset assertion mid-job drops wen and s_ready immediately (asynchronously) and discards the job.
- State machine: IDLE, FILL, PUSH, RELEASE.
- IDLE:
  - start with cfg_total!=0: latch out_total=cfg_total, clear sent-row counter, clear row slot, set busy=1, go to FILL.
  - start with cfg_total==0: ignored; busy stays 0 and done is not pulsed.
  - start while busy: ignored.
- FILL:
  - s_ready=1.
  - Each accepted beat writes s_data into row slot, then increments slot and sent-row counter.
  - Chunk closes on the beat where slot reaches BUFFER_SZ or sent-row counter reaches out_total.
  - On close, in the same edge: out_index=slot count, s_ready=0 next cycle, go to PUSH.
  - Rows above out_index in out_buffer are driven zero; out_buffer is cleared when the next chunk starts filling.
- PUSH:
  - wen=1; out_buffer, out_index, out_total held stable.
  - On sampling pushed=1, go to RELEASE with wen=0 from the next cycle.
- RELEASE:
  - wen=0.
  - Wait for pushed=0 (the array clears pushed after seeing wen low).
  - Then, if sent-row counter==out_total: pulse done, busy=0, go to IDLE. Otherwise clear slot and go to FILL.
  - wen is never re-raised while pushed is still 1.
- Latency:
  - Close-beat edge to wen=1: 1 cycle.
  - pushed=1 sampled to wen=0: 1 cycle.
  - pushed=0 sampled to s_ready=1 (next chunk) or done: 1 cycle.
- Widths:
  - Sent-row counter is STREAM_WIDTH wide and never exceeds out_total; no wrap.
  - out_index never exceeds BUFFER_SZ.
- pushed=1 while in IDLE or FILL is a protocol error: ignored, with no state change.
- s_valid while s_ready=0 is ignored; no data is lost because the upstream holds the beat.
- start and the final RELEASE exit in the same cycle: start ignored, and the job completes normally.

Test Plan (bench ARRAY_DIM=4, BUFFER_SZ=4, BIT_WIDTH=8, INDEX_WIDTH=3):
- Reset then idle: outputs as reset values, out_total=1; s_valid=1 with no start -> s_ready stays 0, wen stays 0.
- cfg_total=4, rows 0x04030201.. -> one chunk, out_index=4, row k matches beat k, wen held until pushed; pushed dropped -> done pulse, busy=0.
- cfg_total=10, array responder acking after 3 cycles -> chunks with out_index 4,4,2; last chunk rows 2-3 zero; out_total=10 on all; exactly one done.
- pushed delayed 20 cycles and s_valid held continuously -> s_ready=0 throughout PUSH/RELEASE, no beat lost or duplicated (scoreboard 10 rows).
- resetn pulled low while wen=1 mid-job -> wen=0 immediately, busy=0; new start with cfg_total=2 -> clean single chunk, out_index=2.
- start with cfg_total=0 -> nothing; start pulsed while busy -> ignored, out_total unchanged.

Source files
------------

// File: rtl/systolic_feeder.sv
// Transmit side of a systolic-array buffer push port: gathers a row stream into chunks of up to
// BUFFER_SZ rows and hands each chunk over with a 4-phase wen/pushed handshake.
module systolic_feeder #(
    parameter int unsigned BIT_WIDTH    = 8,
    parameter int unsigned BUFFER_SZ    = 32,
    parameter int unsigned INDEX_WIDTH  = 6,
    parameter int unsigned ARRAY_DIM    = 32,
    parameter int unsigned STREAM_WIDTH = 32
) (
    input  logic                                    clk,
    input  logic                                    resetn,
    input  logic                                    start,
    input  logic [STREAM_WIDTH-1:0]                 cfg_total,
    input  logic [ARRAY_DIM*BIT_WIDTH-1:0]          s_data,
    input  logic                                    s_valid,
    output logic                                    s_ready,
    output logic [BUFFER_SZ*ARRAY_DIM*BIT_WIDTH-1:0] out_buffer,
    output logic [INDEX_WIDTH-1:0]                  out_index,
    output logic [STREAM_WIDTH-1:0]                 out_total,
    output logic                                    wen,
    input  logic                                    pushed,
    output logic                                    busy,
    output logic                                    done
);

    localparam int unsigned RowW = ARRAY_DIM * BIT_WIDTH;

    typedef enum logic [1:0] {StIdle, StFill, StPush, StRelease} state_e;

    state_e                          state_q, state_d;
    logic [BUFFER_SZ*RowW-1:0]       buf_q;
    logic [INDEX_WIDTH-1:0]          index_q;
    logic [INDEX_WIDTH-1:0]          slot_q;
    logic [STREAM_WIDTH-1:0]         sent_q;
    logic [STREAM_WIDTH-1:0]         total_q;
    logic                            done_q;

    logic                            start_ok;
    logic                            accept;
    logic [INDEX_WIDTH-1:0]          slot_inc;
    logic [STREAM_WIDTH-1:0]         sent_inc;
    logic                            close;
    logic                            rel_exit;
    logic                            rel_last;

    assign start_ok = start && (state_q == StIdle) && (cfg_total != '0);
    assign accept   = s_valid && (state_q == StFill);
    assign slot_inc = slot_q + INDEX_WIDTH'(1);
    assign sent_inc = sent_q + STREAM_WIDTH'(1);
    // A chunk closes when the buffer is full or the job's last row arrives.
    assign close    = accept && ((slot_inc == INDEX_WIDTH'(BUFFER_SZ)) || (sent_inc == total_q));
    assign rel_exit = (state_q == StRelease) && !pushed;
    assign rel_last = rel_exit && (sent_q == total_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start_ok) state_d = StFill;
            StFill:    if (close) state_d = StPush;
            StPush:    if (pushed) state_d = StRelease;
            StRelease: if (rel_exit) state_d = rel_last ? StIdle : StFill;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        s_ready = 1'b0;
        wen     = 1'b0;
        busy    = 1'b1;
        unique case (state_q)
            StIdle:    busy = 1'b0;
            StFill:    s_ready = 1'b1;
            StPush:    wen = 1'b1;
            StRelease: ;
            default:   busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf_q   <= '0;
            index_q <= '0;
            slot_q  <= '0;
            sent_q  <= '0;
            total_q <= STREAM_WIDTH'(1);
            done_q  <= 1'b0;
        end else begin
            done_q <= rel_last;
            if (start_ok) begin
                total_q <= cfg_total;
                sent_q  <= '0;
                slot_q  <= '0;
                index_q <= '0;
                buf_q   <= '0;
            end else if (rel_exit && !rel_last) begin
                // Fresh chunk: unused trailing rows must read back as zero.
                slot_q  <= '0;
                index_q <= '0;
                buf_q   <= '0;
            end else if (accept) begin
                for (int unsigned k = 0; k < BUFFER_SZ; k++) begin
                    if (slot_q == INDEX_WIDTH'(k)) begin
                        buf_q[k*RowW +: RowW] <= s_data;
                    end
                end
                slot_q <= slot_inc;
                sent_q <= sent_inc;
                if (close) begin
                    index_q <= slot_inc;
                end
            end
        end
    end

    assign out_buffer = buf_q;
    assign out_index  = index_q;
    assign out_total  = total_q;
    assign done       = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomised bench for systolic_feeder: a producer/array responder drives jobs and every handed
// chunk is compared against rows sliced from the producer's own row list.
module tb_systolic_feeder;

    localparam int unsigned AD = 4;
    localparam int unsigned BS = 4;
    localparam int unsigned BW = 8;
    localparam int unsigned IW = 3;
    localparam int unsigned SW = 32;
    localparam int unsigned RW = AD * BW;

    logic              clk = 1'b0;
    logic              resetn;
    logic              start;
    logic [SW-1:0]     cfg_total;
    logic [RW-1:0]     s_data;
    logic              s_valid;
    logic              s_ready;
    logic [BS*RW-1:0]  out_buffer;
    logic [IW-1:0]     out_index;
    logic [SW-1:0]     out_total;
    logic              wen;
    logic              pushed;
    logic              busy;
    logic              done;

    int n_cmp = 0;
    int n_err = 0;

    systolic_feeder #(
        .BIT_WIDTH   (BW),
        .BUFFER_SZ   (BS),
        .INDEX_WIDTH (IW),
        .ARRAY_DIM   (AD),
        .STREAM_WIDTH(SW)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .cfg_total (cfg_total),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .out_buffer(out_buffer),
        .out_index (out_index),
        .out_total (out_total),
        .wen       (wen),
        .pushed    (pushed),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One job: producer feeds `total` random rows, responder acks each chunk after ack_dly
    // cycles of wen and holds pushed rel_hold extra cycles after wen drops.
    task automatic run_job(input int total, input int ack_dly, input int rel_hold,
                           input bit gappy, input bit poke_busy, input bit start_at_end,
                           input bit abort_at_wen);
        logic [RW-1:0] rows[$];
        logic [RW-1:0] exp_row;
        int sent, chunk, dones, nchunk, phase, cnt, idx;
        bit finished;
        for (int i = 0; i < total; i++) rows.push_back(RW'($urandom()));
        nchunk = (total + BS - 1) / BS;
        sent = 0; chunk = 0; dones = 0; phase = 0; cnt = 0; finished = 0;

        @(negedge clk);
        start = 1'b1;
        cfg_total = SW'(total);
        @(negedge clk);
        start = 1'b0;
        cfg_total = SW'($urandom());
        check("busy_on", 128'(busy), 128'(1));

        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            if (cyc != 0) @(negedge clk);
            start = 1'b0;
            if (poke_busy && cyc == 2) begin
                start = 1'b1;
                cfg_total = SW'(7);
            end
            if (sent < total && (!gappy || $urandom_range(0, 3) != 0)) begin
                s_valid = 1'b1;
                s_data  = rows[sent];
            end else begin
                s_valid = 1'b0;
            end
            if (s_valid && s_ready) sent++;
            if (done) begin
                dones++;
                check("done_busy", 128'(busy), 128'(0));
                finished = 1;
            end
            case (phase)
                0: begin
                    if (wen) begin
                        if (abort_at_wen) return;
                        check("wen_sready", 128'(s_ready), 128'(0));
                        phase = 1;
                        cnt = 0;
                    end
                end
                1: begin
                    check("wen_hold", 128'(wen), 128'(1));
                    check("push_sready", 128'(s_ready), 128'(0));
                    cnt++;
                    if (cnt >= ack_dly) begin
                        idx = (total - chunk * BS) < BS ? (total - chunk * BS) : BS;
                        check("out_index", 128'(out_index), 128'(idx));
                        check("out_total", 128'(out_total), 128'(total));
                        for (int k = 0; k < BS; k++) begin
                            exp_row = (k < idx) ? rows[chunk * BS + k] : '0;
                            check("row", 128'(out_buffer[k*RW +: RW]), 128'(exp_row));
                        end
                        pushed = 1'b1;
                        phase = 2;
                    end
                end
                2: begin
                    check("wen_drop", 128'(wen), 128'(0));
                    check("rel_sready", 128'(s_ready), 128'(0));
                    cnt = 0;
                    phase = (rel_hold == 0) ? 3 : 4;
                    if (rel_hold == 0) pushed = 1'b0;
                end
                4: begin
                    check("rel_wen", 128'(wen), 128'(0));
                    check("rel_sready", 128'(s_ready), 128'(0));
                    cnt++;
                    if (cnt >= rel_hold) begin
                        pushed = 1'b0;
                        phase = 3;
                    end
                end
                default: ;
            endcase
            // Lower pushed and, on the last chunk, optionally collide a start with the exit.
            if (phase == 3 && !pushed && cnt >= 0 && cnt != -1) begin
                if (start_at_end && chunk == nchunk - 1) begin
                    start = 1'b1;
                    cfg_total = SW'(3);
                end
                phase = 5;
            end else if (phase == 5) begin
                if (chunk == nchunk - 1) check("done_lat", 128'(done), 128'(1));
                else check("next_sready", 128'(s_ready), 128'(1));
                chunk++;
                phase = 0;
            end
        end
        start = 1'b0;
        s_valid = 1'b0;
        check("finished", 128'(finished), 128'(1));
        check("rows_sent", 128'(sent), 128'(total));
        check("chunks", 128'(chunk), 128'(nchunk));
        check("done_count", 128'(dones), 128'(1));
        @(negedge clk);
        check("done_once", 128'(done), 128'(0));
        check("idle_busy", 128'(busy), 128'(0));
    endtask

    initial begin
        resetn = 1'b0;
        start = 1'b0;
        cfg_total = '0;
        s_data = '0;
        s_valid = 1'b0;
        pushed = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sready", 128'(s_ready), 128'(0));
        check("rst_wen", 128'(wen), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_buf", 128'(out_buffer), 128'(0));
        check("rst_index", 128'(out_index), 128'(0));
        check("rst_total", 128'(out_total), 128'(1));
        resetn = 1'b1;

        s_valid = 1'b1;
        s_data = RW'(32'h04030201);
        repeat (4) begin
            @(negedge clk);
            check("idle_sready", 128'(s_ready), 128'(0));
            check("idle_wen", 128'(wen), 128'(0));
        end
        s_valid = 1'b0;

        run_job(4, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_job(10, 3, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        run_job(10, 20, 2, 1'b0, 1'b0, 1'b0, 1'b0);

        run_job(10, 3, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("pre_rst_wen", 128'(wen), 128'(1));
        #2 resetn = 1'b0;
        s_valid = 1'b0;
        #1;
        check("arst_wen", 128'(wen), 128'(0));
        check("arst_sready", 128'(s_ready), 128'(0));
        check("arst_busy", 128'(busy), 128'(0));
        check("arst_total", 128'(out_total), 128'(1));
        @(negedge clk);
        resetn = 1'b1;
        run_job(2, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        start = 1'b1;
        cfg_total = '0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            check("zero_busy", 128'(busy), 128'(0));
            check("zero_done", 128'(done), 128'(0));
            check("zero_sready", 128'(s_ready), 128'(0));
            @(negedge clk);
        end
        check("zero_total", 128'(out_total), 128'(2));

        run_job(5, 1, 1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("end_start_total", 128'(out_total), 128'(5));

        for (int j = 0; j < 5; j++) begin
            run_job($urandom_range(1, 13), $urandom_range(1, 5), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
